// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// Decodes the I/S/B/U/J/shamt immediates of each accepted instruction, then
// registers the result into a 2-entry (head + skid) output buffer. The buffer
// keeps full throughput under back-pressure, and results leave in strict FIFO
// order one cycle after acceptance.
// Optional feature: define IMM_CSR_EN to decode the CSR-immediate forms
// (csrrwi/csrrsi/csrrci) as format 7. Without it, opcode 1110011 decodes as NONE.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Sign-extend a 32-bit immediate (sign bit is inst[31]) to XLEN.
    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       shamt_ok;
    entry_t     dec;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // Shift-immediate legality: the bits above shamt select slli/srli or srai.
    always_comb begin
        shamt_ok = 1'b0;
        if (XLEN == 64) begin
            shamt_ok = (in_inst[31:26] == 6'b000000) ||
                       (in_inst[31:26] == 6'b010000 && funct3 == 3'b101);
        end else begin
            shamt_ok = (in_inst[31:25] == 7'b0000000) ||
                       (in_inst[31:25] == 7'b0100000 && funct3 == 3'b101);
        end
    end

    // Combinational decode of the incoming instruction word.
    always_comb begin
        // NOTE: every field gets a default first so no path through the case leaves a latch.
        dec         = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        dec.tag     = in_tag;
        if (in_inst[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_JALR: begin
                    dec.fmt = FMT_I;
                    dec.imm = sx({{20{in_inst[31]}}, in_inst[31:20]});
                end
                OP_IMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec.fmt = FMT_SHAMT;
                        if (!shamt_ok) begin
                            dec.illegal = 1'b1;
                        end else if (XLEN == 64) begin
                            dec.imm = XLEN'(in_inst[25:20]);
                        end else begin
                            dec.imm = XLEN'(in_inst[24:20]);
                        end
                    end else begin
                        dec.fmt = FMT_I;
                        dec.imm = sx({{20{in_inst[31]}}, in_inst[31:20]});
                    end
                end
                OP_STORE: begin
                    dec.fmt = FMT_S;
                    dec.imm = sx({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
                end
                OP_BRANCH: begin
                    dec.fmt = FMT_B;
                    dec.imm = sx({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                  in_inst[30:25], in_inst[11:8], 1'b0});
                end
                OP_LUI, OP_AUIPC: begin
                    dec.fmt = FMT_U;
                    dec.imm = sx({in_inst[31:12], 12'b0});
                end
                OP_JAL: begin
                    dec.fmt = FMT_J;
                    dec.imm = sx({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                  in_inst[20], in_inst[30:21], 1'b0});
                end
`ifdef IMM_CSR_EN
                OP_SYSTEM: begin
                    if (funct3[2]) begin
                        dec.fmt = FMT_CSR;
                        dec.imm = XLEN'(in_inst[19:15]);
                    end
                end
`else
                OP_SYSTEM: begin
                    dec.fmt = FMT_NONE;
                end
`endif
                default: begin
                    dec.fmt = FMT_NONE;
                end
            endcase
        end
    end

    // Output buffer state: head drives out_*, skid catches one extra entry.
    logic [1:0] count_q, count_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic       in_ready_q;
    logic       push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // Next buffer state; flush voids any handshake in the same cycle.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = dec;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = dec;
                    end else if (push) begin
                        skid_d  = dec;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
    end

    // Buffer registers; in_ready is registered from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data entries are reset too, because out_* must read zero straight out of reset.
        if (!rst_n) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count_q    <= count_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;
    assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// all inputs. Directed vector table, hand-written buffer/flush/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [3:0]  out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [3:0]  out_tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of one instruction for both widths.
    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill32;
        logic        ill64;
        logic [3:0]  tag;
    } exp_t;

    // Reference decode built from shifts and masks on the whole word.
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [3:0] tag);
        exp_t   r;
        longint si = longint'($signed(inst));
        longint u  = longint'({32'd0, inst});
        longint v  = 0;
        longint op = u & 127;
        longint f3 = (u >> 12) & 7;
        r.fmt = 3'd0; r.ill32 = 1'b0; r.ill64 = 1'b0; r.tag = tag;
        r.imm32 = '0; r.imm64 = '0;
        if ((u & 3) != 3) begin
            r.ill32 = 1'b1; r.ill64 = 1'b1;
            return r;
        end
        if (op == 19 && (f3 == 1 || f3 == 5)) begin
            longint top7 = u >> 25;
            longint top6 = u >> 26;
            r.fmt = 3'd6;
            r.ill32 = !(top7 == 0 || (top7 == 32 && f3 == 5));
            r.ill64 = !(top6 == 0 || (top6 == 16 && f3 == 5));
            r.imm32 = r.ill32 ? 32'd0 : 32'((u >> 20) & 31);
            r.imm64 = r.ill64 ? 64'd0 : 64'((u >> 20) & 63);
            return r;
        end
        if (op == 3 || op == 103 || op == 19) begin
            r.fmt = 3'd1; v = si >>> 20;
        end else if (op == 35) begin
            r.fmt = 3'd2; v = ((si >>> 25) << 5) | ((u >> 7) & 31);
        end else if (op == 99) begin
            r.fmt = 3'd3;
            v = ((si >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        end else if (op == 55 || op == 23) begin
            r.fmt = 3'd4; v = si & -64'sd4096;
        end else if (op == 111) begin
            r.fmt = 3'd5;
            v = ((si >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        end
`ifdef IMM_CSR_EN
        else if (op == 115 && f3 >= 4) begin
            r.fmt = 3'd7; v = (u >> 15) & 31;
        end
`endif
        r.imm64 = 64'(v);
        r.imm32 = 32'(v);
        return r;
    endfunction

    // Directed vectors with hand-computed expectations.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill32;
        logic        ill64;
    } vec_t;

    vec_t vecs[14];
    exp_t sb[$];

    // Compare both DUTs' head against one expected entry.
    task automatic check_head(input string name, input exp_t e);
        check({name, ".imm32"}, {32'd0, out_imm}, {32'd0, e.imm32});
        check({name, ".imm64"}, out_imm64, e.imm64);
        check({name, ".fmt32"}, {61'd0, out_fmt}, {61'd0, e.fmt});
        check({name, ".fmt64"}, {61'd0, out_fmt64}, {61'd0, e.fmt});
        check({name, ".ill32"}, {63'd0, out_illegal}, {63'd0, e.ill32});
        check({name, ".ill64"}, {63'd0, out_illegal64}, {63'd0, e.ill64});
        check({name, ".tag"}, {60'd0, out_tag}, {60'd0, e.tag});
        check({name, ".tag64"}, {60'd0, out_tag64}, {60'd0, e.tag});
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[10] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
        logic [31:0] w = $urandom;
        if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(9)];
        if (w[6:0] == 7'h13 && $urandom_range(1) == 1) begin
            w[31:26] = ($urandom_range(1) == 1) ? 6'b010000 : 6'b000000;
            if ($urandom_range(1) == 1) w[25] = 1'b0;
        end
        return w;
    endfunction

    initial begin
        exp_t e;
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{32'h4030D093, 32'h00000003, 64'h3,                3'd6, 1'b0, 1'b0};
        vecs[2]  = '{32'h2030D093, 32'h00000000, 64'h0,                3'd6, 1'b1, 1'b1};
        vecs[3]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 1'b0};
        vecs[4]  = '{32'h0080006F, 32'h00000008, 64'h8,                3'd5, 1'b0, 1'b0};
        vecs[5]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0};
        vecs[6]  = '{32'hFE20AC23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 32'h00000000, 64'h0,                3'd0, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000033, 32'h00000000, 64'h0,                3'd0, 1'b0, 1'b0};
`ifdef IMM_CSR_EN
        vecs[9]  = '{32'h0057D073, 32'h0000000F, 64'hF,                3'd7, 1'b0, 1'b0};
`else
        vecs[9]  = '{32'h0057D073, 32'h00000000, 64'h0,                3'd0, 1'b0, 1'b0};
`endif
        vecs[10] = '{32'h02009093, 32'h00000000, 64'h20,               3'd6, 1'b1, 1'b0};
        vecs[11] = '{32'h40009093, 32'h00000000, 64'h0,                3'd6, 1'b1, 1'b1};
        vecs[12] = '{32'h00001097, 32'h00001000, 64'h1000,             3'd4, 1'b0, 1'b0};
        vecs[13] = '{32'h000080E7, 32'h00000000, 64'h0,                3'd1, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);
        e = '{32'd0, 64'd0, 3'd0, 1'b0, 1'b0, 4'd0};
        check_head("rst", e);
        rst_n = 1'b1;

        // Directed table, out_ready held high: each result visible one cycle later.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_tag   = 4'(i);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d.out_valid", i), {63'd0, out_valid}, 64'd1);
            e = '{vecs[i].imm32, vecs[i].imm64, vecs[i].fmt, vecs[i].ill32, vecs[i].ill64, 4'(i)};
            check_head($sformatf("vec%0d", i), e);
        end
        @(negedge clk);
        check("drain.out_valid", {63'd0, out_valid}, 64'd0);

        // Back-pressure: two entries fill the buffer, third waits, then no-gap drain.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 4'd1;
        @(posedge clk); @(negedge clk);
        in_tag = 4'd2;
        @(posedge clk); @(negedge clk);
        check("bp.in_ready_full", {63'd0, in_ready}, 64'd0);
        check("bp.tag1", {60'd0, out_tag}, 64'd1);
        in_tag = 4'd3;
        @(posedge clk); @(negedge clk);
        check("bp.held_tag1", {60'd0, out_tag}, 64'd1);
        check("bp.held_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp.valid2", {63'd0, out_valid}, 64'd1);
        check("bp.tag2", {60'd0, out_tag}, 64'd2);
        check("bp.in_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("bp.valid3", {63'd0, out_valid}, 64'd1);
        check("bp.tag3", {60'd0, out_tag}, 64'd3);
        @(posedge clk); @(negedge clk);
        check("bp.empty", {63'd0, out_valid}, 64'd0);

        // Flush at count=2 with a competing input: nothing survives.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'd5;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("fl.full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1; out_ready = 1'b1; in_tag = 4'd6;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid", {63'd0, out_valid}, 64'd0);
        check("fl.in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("fl.still_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with a full buffer clears state without a clock edge.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'd9;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", {63'd0, out_valid}, 64'd0);
        check("arst.in_ready", {63'd0, in_ready}, 64'd1);
        check("arst.tag", {60'd0, out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the queue model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            check("rnd.out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
            check("rnd.in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
            check("rnd.in_ready64", {63'd0, in_ready64}, {63'd0, sb.size() < 2});
            flush     = ($urandom_range(31) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_inst   = rand_inst();
            in_tag    = 4'($urandom);
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() != 0) begin
                    check_head("rnd", sb[0]);
                    void'(sb.pop_front());
                end
                if (in_valid && in_ready) sb.push_back(ref_decode(in_inst, in_tag));
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
